// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial N-bit subtractor with start/done handshake
//
// Computes (a - b - bin) mod 2^N one bit per clock, LSB first, using a single
// full-subtractor cell and a borrow flip-flop. A result is produced every N+1
// cycles when requests are issued back to back.
//
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   rst   - synchronous, active-high reset
//   a     - minuend, sampled on the accepting edge only
//   b     - subtrahend, sampled on the accepting edge only
//   bin   - borrow-in, sampled on the accepting edge only
//   start - request, accepted in IDLE or DONE
//   diff  - registered result, held until the next completion
//   bout  - registered borrow-out, 1 iff a < b + bin (unsigned)
//   busy  - high while bits are being processed
//   done  - one-cycle pulse when diff/bout update
module serial_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    input  logic         start,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [N-1:0]    sa_q;
    logic [N-1:0]    sb_q;
    // Holds the N-1 difference bits produced so far; the last bit is
    // concatenated on top in the final cycle.
    logic [N-2:0]    res_q;
    logic            br_q;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    diff_q;
    logic            bout_q;
    logic            busy_q;
    logic            done_q;

    logic            d_bit;
    logic            br_d;
    logic [N-1:0]    res_full;
    logic            accept;
    logic            last_bit;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        d_bit    = sa_q[0] ^ sb_q[0] ^ br_q;
        br_d     = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        res_full = {d_bit, res_q};
        accept   = start && ((state_q == IDLE) || (state_q == DONE));
        last_bit = (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (accept) begin
            state_q <= SHIFT;
            sa_q    <= a;
            sb_q    <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                SHIFT: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    br_q  <= br_d;
                    res_q <= res_full[N-1:1];
                    cnt_q <= cnt_q + CW'(1);
                    if (last_bit) begin
                        diff_q  <= res_full;
                        bout_q  <= br_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // No new request this cycle, so the pulse ends here.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         bin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .start (start),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    // Reference model: a request accepted while not busy completes N edges
    // later with the arithmetic result of the captured operands.
    int           ea, eb, ebin, m_cnt;
    logic         m_busy, m_done, m_bout;
    logic [N-1:0] m_diff;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_bout <= 1'b0;
            m_cnt  <= 0;
        end else if (!m_busy && start) begin
            ea     <= int'(a);
            eb     <= int'(b);
            ebin   <= int'(bin);
            m_cnt  <= N;
            m_busy <= 1'b1;
            m_done <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_diff <= N'(ea - eb - ebin);
                m_bout <= (ea < eb + ebin);
            end
            m_cnt <= m_cnt - 1;
        end else begin
            m_done <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model busy", busy, m_busy);
            check("model done", done, m_done);
            check("model diff", diff, m_diff);
            check("model bout", bout, m_bout);
            check("busy_done_exclusive", busy & done, 0);
        end
    end

    task automatic do_op(input string tag, input int ia, input int ib, input int ibin,
                         input logic [N-1:0] xd, input logic xb);
        int lat;
        int nbusy;
        bit got;
        a     = N'(ia);
        b     = N'(ib);
        bin   = ibin[0];
        start = 1'b1;
        lat   = 0;
        nbusy = 0;
        got   = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                got = 1'b1;
                lat = k - 1;
                break;
            end
        end
        check({tag, " done_seen"}, got, 1);
        check({tag, " latency"}, lat, N);
        check({tag, " busy_cycles"}, nbusy, N);
        check({tag, " diff"}, diff, xd);
        check({tag, " bout"}, bout, xb);
        @(negedge clk);
        check({tag, " done_one_cycle"}, done, 0);
    endtask

    initial begin
        int ndone;
        int lat;
        bit got;
        logic [N-1:0] cap_d;
        logic cap_b;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset diff", diff, 0);
        check("reset bout", bout, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op("10-6-0", 10, 6, 0, 4'b0100, 1'b0);
        do_op("13-14-1", 13, 14, 1, 4'b1110, 1'b1);
        do_op("0-0-1", 0, 0, 1, 4'b1111, 1'b1);
        do_op("15-15-0", 15, 15, 0, 4'b0000, 1'b0);
        do_op("15-0-0", 15, 0, 0, 4'b1111, 1'b0);

        // Second request during SHIFT must be ignored.
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd1; b = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        cap_d = '0;
        cap_b = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                cap_d = diff;
                cap_b = bout;
            end
        end
        check("ignored_start done_count", ndone, 1);
        check("ignored_start diff", cap_d, 4'd6);
        check("ignored_start bout", cap_b, 1'b0);

        // start held through DONE: second op accepted in the DONE cycle.
        a = 4'd10; b = 4'd6; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 4'd3; b = 4'd5; bin = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("b2b first done_seen", got, 1);
        check("b2b first diff", diff, 4'd4);
        @(negedge clk);
        start = 1'b0;
        check("b2b reaccept busy", busy, 1);
        check("b2b reaccept done", done, 0);
        got = 1'b0;
        lat = 0;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                lat = k;
                break;
            end
        end
        check("b2b second done_seen", got, 1);
        check("b2b second spacing", lat, N + 1);
        check("b2b second diff", diff, 4'b1110);
        check("b2b second bout", bout, 1'b1);

        // Reset two cycles into an operation aborts it.
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort diff", diff, 0);
        check("abort bout", bout, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        @(negedge clk);
        check("abort stays idle busy", busy, 0);
        do_op("after_reset 7-2", 7, 2, 0, 4'd5, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
